// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and total-period helpers.
package vga_timing_pkg;

    typedef logic [15:0] coord_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int h_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-stream bundle between the timing generator and its frame-buffer/display side.
interface vga_timing_gen_if import vga_timing_pkg::*; #(
    parameter int RGB_W  = 3,
    parameter int ADDR_W = 19
) ();

    logic              iEnable;
    logic [RGB_W-1:0]  iColor;
    logic              oHs;
    logic              oVs;
    logic [RGB_W-1:0]  oRGB;
    logic              oDisplayEnable;
    coord_t            oColumn;
    coord_t            oRow;
    logic [ADDR_W-1:0] oColorAddress;
    logic              oLineStart;
    logic              oFrameStart;

    modport master (
        input  iEnable, iColor,
        output oHs, oVs, oRGB, oDisplayEnable, oColumn, oRow,
               oColorAddress, oLineStart, oFrameStart
    );

    modport slave (
        output iEnable, iColor,
        input  oHs, oVs, oRGB, oDisplayEnable, oColumn, oRow,
               oColorAddress, oLineStart, oFrameStart
    );

endinterface

// File: rtl/vga_pixel_tick.sv
// Pixel clock-enable: one-Clock pulse every CLK_DIV enabled cycles; phase freezes while disabled.
module vga_pixel_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on phase 0 so the first enabled cycle after reset already emits a pixel.
    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i)
            cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank generator: column/row counters, registered syncs, display enable,
// incremental frame-buffer address and one-pixel-delayed colour output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int RGB_W    = 3,
    parameter int ADDR_W   = 19
) (
    input  logic Clock,
    input  logic Reset,
    vga_timing_gen_if.master vga
);

    localparam int     H_TOTAL    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL    = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam coord_t H_ACT_C    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C    = coord_t'(V_ACTIVE);
    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t HS_BEG     = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_BEG     = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        CLK_DIV < 1 ||
        longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_bad_params
        $error("vga_timing_gen: zero porch/sync, CLK_DIV<1 or frame exceeds address space");
    end

    logic tick;

    vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .Clock  (Clock),
        .Reset  (Reset),
        .en_i   (vga.iEnable),
        .tick_o (tick)
    );

    // col_q/row_q name the pixel the next tick emits; pcol_q/prow_q the pixel on the outputs.
    coord_t            col_q, col_d, row_q, row_d, pcol_q, pcol_d, prow_q, prow_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        pcol_d = pcol_q;
        prow_d = prow_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        de_d   = de_q;
        rgb_d  = rgb_q;
        addr_d = addr_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        if (tick) begin
            pcol_d = col_q;
            prow_d = row_q;
            hs_d   = (col_q >= HS_BEG && col_q < HS_END) ? HS_POL : ~HS_POL;
            vs_d   = (row_q >= VS_BEG && row_q < VS_END) ? VS_POL : ~VS_POL;
            de_d   = (col_q < H_ACT_C) && (row_q < V_ACT_C);
            rgb_d  = de_d ? vga.iColor : '0;
            ls_d   = (col_q == '0);
            fs_d   = (col_q == '0) && (row_q == '0);
            // Address already points at the pixel being shown; advance to the next visible one.
            if (de_d)
                addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            col_q  <= '0;
            row_q  <= '0;
            pcol_q <= '0;
            prow_q <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            rgb_q  <= '0;
            addr_q <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            pcol_q <= pcol_d;
            prow_q <= prow_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            rgb_q  <= rgb_d;
            addr_q <= addr_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign vga.oHs            = hs_q;
    assign vga.oVs            = vs_q;
    assign vga.oRGB           = rgb_q;
    assign vga.oDisplayEnable = de_q;
    assign vga.oColumn        = pcol_q;
    assign vga.oRow           = prow_q;
    assign vga.oColorAddress  = addr_q;
    assign vga.oLineStart     = ls_q;
    assign vga.oFrameStart    = fs_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync width and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync width and back porch in lines.
REQ-005 Parameter HS_POL / VS_POL, default 0 / 0, asserted level of each sync (0 = active-low).
REQ-006 Parameter CLK_DIV, default 2, Clock cycles per pixel (>=1).
REQ-007 Parameter RGB_W, default 3, colour width; ADDR_W, default 19, address width.
REQ-008 Clock  in  1  system clock; all logic on rising edge.
REQ-009 Reset  in  1  asynchronous, active-low reset.
REQ-010 iEnable  in  1  1 = run; 0 = freeze all counters and outputs at current values.
REQ-011 iColor  in  RGB_W  pixel colour for the address presented one pixel earlier.
REQ-012 oHs, oVs  out  1  horizontal/vertical sync at HS_POL/VS_POL.
REQ-013 oRGB  out  RGB_W  iColor during display window, else zero.
REQ-014 oDisplayEnable  out  1  high only during visible pixels.
REQ-015 oColumn  out  16, oRow  out  16  current pixel coordinates (full counter values incl. blanking).
REQ-016 oColorAddress  out  ADDR_W  linear frame-buffer address of the next visible pixel.
REQ-017 oLineStart, oFrameStart  out  1  one-Clock strobes.

Function
REQ-018 Pixel tick SHALL pulse one Clock in every CLK_DIV while iEnable=1; all counters advance only on ticks.
REQ-019 Column counts 0..H_TOTAL-1 (H_TOTAL = sum of H parameters), wraps to 0 and increments row; row counts 0..V_TOTAL-1 and wraps to 0.
REQ-020 oHs asserted for column in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; oVs asserted for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], over whole lines.
REQ-021 oDisplayEnable = (column < H_ACTIVE) and (row < V_ACTIVE).
REQ-022 All outputs registered; oHs, oVs, oDisplayEnable, oColumn, oRow SHALL refer to the same pixel with zero relative skew.
REQ-023 oColorAddress SHALL be computed incrementally (no multiplier): +1 on each visible-pixel tick, holds during blanking, returns to 0 on frame wrap; value equals row*H_ACTIVE+column+1 after each visible pixel.
REQ-024 oRGB SHALL present iColor registered one pixel after its address, and zero whenever the delayed display-enable is low.
REQ-025 oLineStart pulses on the tick where column wraps to 0; oFrameStart pulses on the tick where column and row both wrap to 0 (both strobes high then).
REQ-026 iEnable falling mid-line freezes state; rising resumes from the frozen pixel without a tick being skipped or doubled.
REQ-027 Elaboration SHALL fail if any porch/sync parameter is 0 or H_ACTIVE*V_ACTIVE exceeds 2**ADDR_W.

Reset
REQ-028 On Reset=0: column=0, row=0, divider=0, oColorAddress=0, oRGB=0, oDisplayEnable=0, strobes=0, oHs=~HS_POL, oVs=~VS_POL.
REQ-029 Reset assertion mid-frame SHALL take effect immediately; first tick after release SHALL emit pixel (0,0) with oFrameStart=1.

Structure
REQ-030 Package vga_timing_pkg holds the 640x480@60 default timing constants and H_TOTAL/V_TOTAL derivation functions.
REQ-031 One sub-module vga_pixel_tick (parametrised CLK_DIV clock-enable generator); sync/blank logic stays in vga_timing_gen.

Verification
REQ-032 Defaults, run 1 frame -> line period 1600 Clock, oHs low 192 Clock starting at column 656, frame period 840000 Clock.
REQ-033 Defaults -> oVs low for exactly 2 lines starting row 490; oDisplayEnable high 307200 ticks per frame.
REQ-034 Last visible pixel (639,479) -> oColorAddress 307199 presented for it, then 0 held through blanking until next frame.
REQ-035 HS_POL=1, CLK_DIV=1, H/V=8/4 active, porches 1/2/1 -> oHs high 2 Clock per 12-Clock line, frame 12*8 Clock.
REQ-036 iEnable low 50 Clock at column 300 -> all outputs constant; column 301 follows exactly one tick after re-enable.
REQ-037 Reset pulse at row 200 -> outputs at reset values within same Clock; oFrameStart on first tick after release.
